// File: rtl/core_scheduler_if.sv
// Host/core-side signal bundle for core_scheduler.
// The master side is the host plus the core_N end_process sources.
// The slave side is the scheduler itself.
interface core_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int CNT_W     = 16
);
  logic                   start;
  logic [NUM_CORES-1:0]   core_mask;
  logic [NUM_CORES-1:0]   end_process;
  logic [2*NUM_CORES-1:0] status;
  logic                   busy;
  logic                   done;
  logic                   timed_out;
  logic [NUM_CORES-1:0]   finished;
  logic [CNT_W-1:0]       cycles;

  modport master (
    output start, core_mask, end_process,
    input  status, busy, done, timed_out, finished, cycles
  );

  modport slave (
    input  start, core_mask, end_process,
    output status, busy, done, timed_out, finished, cycles
  );
endinterface

// File: rtl/core_scheduler.sv
// core_scheduler: launches a masked group of matrix-multiplication cores,
// tracks per-core completion, counts run cycles and applies an optional
// run-cycle timeout. One done pulse is reported per accepted start.
// Every output is decoded from registered state only.
module core_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 0
) (
  input  logic            clock,
  input  logic            reset,
  core_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] ST_HOLD     = 2'b00;
  localparam logic [1:0] ST_RUN      = 2'b01;
  localparam logic [1:0] ST_COMPLETE = 2'b10;

  state_t                 state;
  logic [NUM_CORES-1:0]   active_mask;
  logic [NUM_CORES-1:0]   finished;
  logic [CNT_W-1:0]       cycles;
  logic                   timed_out;

  logic [NUM_CORES-1:0]   fin_next;
  logic [CNT_W-1:0]       cycles_inc;
  logic                   timeout_hit;
  logic [2*NUM_CORES-1:0] status_d;

  // Next-state helpers for RUN: merged completion, saturating count, timeout test
  always_comb begin
    fin_next    = finished | (bus.end_process & active_mask);
    cycles_inc  = (&cycles) ? cycles : cycles + CNT_W'(1);
    timeout_hit = (TIMEOUT != 0) && (cycles_inc == CNT_W'(TIMEOUT));
  end

  // Scheduler FSM with its job bookkeeping registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      active_mask <= '0;
      finished    <= '0;
      cycles      <= '0;
      timed_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // An empty mask still counts as a job: it completes at once.
            active_mask <= bus.core_mask;
            finished    <= '0;
            cycles      <= '0;
            timed_out   <= 1'b0;
            state       <= (bus.core_mask != '0) ? LAUNCH : DONE;
          end
        end
        LAUNCH: begin
          // One guaranteed HOLD cycle so every selected core resets its PC.
          state <= RUN;
        end
        RUN: begin
          cycles   <= cycles_inc;
          finished <= fin_next;
          // Completion wins over a timeout landing on the same edge.
          if (fin_next == active_mask) begin
            state <= DONE;
          end else if (timeout_hit) begin
            timed_out <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Per-core status decode from state, active mask and latched completion
  always_comb begin
    status_d = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      case (state)
        RUN: begin
          if (finished[i])         status_d[2*i +: 2] = ST_COMPLETE;
          else if (active_mask[i]) status_d[2*i +: 2] = ST_RUN;
          else                     status_d[2*i +: 2] = ST_HOLD;
        end
        DONE: begin
          status_d[2*i +: 2] = finished[i] ? ST_COMPLETE : ST_HOLD;
        end
        default: begin
          status_d[2*i +: 2] = ST_HOLD;
        end
      endcase
    end
  end

  assign bus.status    = status_d;
  assign bus.busy      = (state == LAUNCH) || (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.timed_out = timed_out;
  assign bus.finished  = finished;
  assign bus.cycles    = cycles;

endmodule
